// File: rtl/srsc_frame_sequencer.sv
// Frame sequencer for the SRSC datapath: a priming frame feeds A estimation, then recovery frames run with a double-buffered A.
// Latency: no latency on pixel data; status pulses appear one cycle after their triggering event.
// Backpressure: o_pix_ready is low outside PRIME/RUN, and it is held low while A is missing (WAIT_A) and during DRAIN.
module srsc_frame_sequencer #(
  parameter int         IMG_W     = 512,
  parameter int         IMG_H     = 512,
  parameter logic [7:0] A_DEFAULT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_pix_valid,
  output logic       o_pix_ready,
  input  logic [7:0] i_ale_r,
  input  logic [7:0] i_ale_g,
  input  logic [7:0] i_ale_b,
  input  logic       i_ale_valid,
  input  logic       i_srsc_valid,
  output logic [7:0] o_a_r,
  output logic [7:0] o_a_g,
  output logic [7:0] o_a_b,
  output logic       o_ale_in_valid,
  output logic       o_frame_start,
  output logic       o_frame_done,
  output logic       o_a_stale,
  output logic       o_done,
  output logic       o_busy
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int OW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(TOTAL - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_WAIT_A = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [OW-1:0] out_cnt;
  logic [7:0]    shadow_r;
  logic [7:0]    shadow_g;
  logic [7:0]    shadow_b;
  logic          shadow_v;
  logic          stop_q;

  logic accept;
  logic fe;
  logic a_avail;
  logic counting;
  logic out_wrap;
  logic start_run;
  logic swap;
  logic stale_evt;
  logic done_evt;

  // Status outputs are pure decodes of the registered state.
  assign o_pix_ready    = (state == S_PRIME) || (state == S_RUN);
  assign o_ale_in_valid = (state == S_RUN) || (state == S_DRAIN);
  assign o_busy         = (state != S_IDLE);

  assign accept    = i_pix_valid && o_pix_ready;
  assign fe        = accept && (col == COL_LAST) && (row == ROW_LAST);
  assign a_avail   = shadow_v || i_ale_valid;
  assign counting  = (state == S_RUN) || (state == S_DRAIN);
  assign out_wrap  = counting && i_srsc_valid && (out_cnt == OUT_LAST);
  assign start_run = (state == S_IDLE) && i_start;

  // Next state plus the frame-boundary decisions: A swap, stale-A report, drain completion.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    stale_evt = 1'b0;
    done_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (fe) begin
          if (a_avail) begin
            swap      = 1'b1;
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_WAIT_A;
          end
        end
      end
      S_WAIT_A: begin
        if (i_ale_valid) begin
          swap      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (fe) begin
          if (a_avail) swap = 1'b1;
          else         stale_evt = 1'b1;
          if (stop_q || i_stop) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A zero count here means every output of the last frame has already arrived.
        if (out_wrap || (out_cnt == '0)) begin
          done_evt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Input raster position; col wraps into row, both wrap at frame end.
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Shadow A and stop latch; a swap consumes the shadow even when a new strobe lands on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= '0;
      shadow_g <= '0;
      shadow_b <= '0;
      shadow_v <= 1'b0;
      stop_q   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (i_start) begin
        shadow_v <= 1'b0;
        stop_q   <= 1'b0;
      end
    end else begin
      if (i_ale_valid) begin
        shadow_r <= i_ale_r;
        shadow_g <= i_ale_g;
        shadow_b <= i_ale_b;
      end
      shadow_v <= swap ? 1'b0 : (i_ale_valid ? 1'b1 : shadow_v);
      if (i_stop && (state != S_DRAIN)) stop_q <= 1'b1;
    end
  end

  // Active A only changes on a swap, so it is constant over every pixel of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_a_r <= A_DEFAULT;
      o_a_g <= A_DEFAULT;
      o_a_b <= A_DEFAULT;
    end else if (swap) begin
      o_a_r <= i_ale_valid ? i_ale_r : shadow_r;
      o_a_g <= i_ale_valid ? i_ale_g : shadow_g;
      o_a_b <= i_ale_valid ? i_ale_b : shadow_b;
    end
  end

  // SRSC output counter; wraps once per frame's worth of recovered pixels.
  always_ff @(posedge clk) begin
    if (rst || start_run || done_evt) begin
      out_cnt <= '0;
    end else if (counting && i_srsc_valid) begin
      out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + OW'(1);
    end
  end

  // Registered one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_a_stale     <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_frame_start <= accept && (col == '0) && (row == '0);
      o_frame_done  <= out_wrap;
      o_a_stale     <= stale_evt;
      o_done        <= done_evt;
    end
  end

endmodule

// File: tb/tb_srsc_frame_sequencer.sv
// Directed bench for srsc_frame_sequencer on a 4x2 frame.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Status tuple {o_busy, o_pix_ready, o_ale_in_valid}: IDLE=000 PRIME=110 WAIT_A=100 RUN=111 DRAIN=101.
module tb_srsc_frame_sequencer;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic       i_stop;
  logic       i_pix_valid;
  logic       o_pix_ready;
  logic [7:0] i_ale_r;
  logic [7:0] i_ale_g;
  logic [7:0] i_ale_b;
  logic       i_ale_valid;
  logic       i_srsc_valid;
  logic [7:0] o_a_r;
  logic [7:0] o_a_g;
  logic [7:0] o_a_b;
  logic       o_ale_in_valid;
  logic       o_frame_start;
  logic       o_frame_done;
  logic       o_a_stale;
  logic       o_done;
  logic       o_busy;

  srsc_frame_sequencer #(.IMG_W(W), .IMG_H(H), .A_DEFAULT(8'd255)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
    .i_ale_r(i_ale_r), .i_ale_g(i_ale_g), .i_ale_b(i_ale_b), .i_ale_valid(i_ale_valid),
    .i_srsc_valid(i_srsc_valid),
    .o_a_r(o_a_r), .o_a_g(o_a_g), .o_a_b(o_a_b), .o_ale_in_valid(o_ale_in_valid),
    .o_frame_start(o_frame_start), .o_frame_done(o_frame_done), .o_a_stale(o_a_stale),
    .o_done(o_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  wire [2:0]  st = {o_busy, o_pix_ready, o_ale_in_valid};
  wire [23:0] a  = {o_a_r, o_a_g, o_a_b};
  wire [3:0]  pulses = {o_frame_start, o_frame_done, o_a_stale, o_done};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ale(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    i_ale_valid = v;
    i_ale_r = r;
    i_ale_g = g;
    i_ale_b = b;
  endtask

  int cnt_a;
  int cnt_b;
  int cyc_a;
  int cyc_b;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_pix_valid = 1'b0; i_srsc_valid = 1'b0;
    set_ale(1'b0, 8'd0, 8'd0, 8'd0);
    tick; tick;
    chk("rst_status", 32'(st), 32'(3'b000));
    chk("rst_a", 32'(a), 32'({8'd255, 8'd255, 8'd255}));
    chk("rst_pulses", 32'(pulses), 32'(4'b0000));
    rst = 1'b0;
    tick;
    chk("idle_hold", 32'(st), 32'(3'b000));

    // Priming frame with an A estimate at pixel 5
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("prime_status", 32'(st), 32'(3'b110));
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      i_pix_valid = 1'b1;
      if (i == 5) set_ale(1'b1, 8'd90, 8'd80, 8'd70);
      else        set_ale(1'b0, 8'd0, 8'd0, 8'd0);
      tick;
      if (!o_pix_ready) cnt_a++;
      if (i == 0) chk("prime_frame_start", 32'(o_frame_start), 32'd1);
      if (i == 5) chk("prime_a_held", 32'(a), 32'({8'd255, 8'd255, 8'd255}));
    end
    i_pix_valid = 1'b0; set_ale(1'b0, 8'd0, 8'd0, 8'd0);
    chk("prime_ready_drops", 32'(cnt_a), 32'd0);
    chk("prime_to_run", 32'(st), 32'(3'b111));
    chk("prime_swap_a", 32'(a), 32'({8'd90, 8'd80, 8'd70}));

    // Recovery frame without a new A: stale report, A kept
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      i_pix_valid = 1'b1;
      tick;
      if (o_a_stale) cnt_a++;
      if (i == 0) chk("run_frame_start", 32'(o_frame_start), 32'd1);
    end
    i_pix_valid = 1'b0;
    chk("stale_a_kept", 32'(a), 32'({8'd90, 8'd80, 8'd70}));
    tick;
    if (o_a_stale) cnt_a++;
    chk("stale_once", 32'(cnt_a), 32'd1);
    chk("stale_still_run", 32'(st), 32'(3'b111));

    // A strobe landing exactly on the frame-end pixel
    for (int i = 0; i < 8; i++) begin
      i_pix_valid = 1'b1;
      if (i == 7) set_ale(1'b1, 8'd11, 8'd22, 8'd33);
      else        set_ale(1'b0, 8'd0, 8'd0, 8'd0);
      tick;
      if (i == 6) chk("a_const_in_frame", 32'(a), 32'({8'd90, 8'd80, 8'd70}));
    end
    i_pix_valid = 1'b0; set_ale(1'b0, 8'd0, 8'd0, 8'd0);
    chk("fe_ale_a", 32'(a), 32'({8'd11, 8'd22, 8'd33}));
    chk("fe_ale_shadow_v", 32'(dut.shadow_v), 32'd0);
    chk("fe_ale_no_stale", 32'(o_a_stale), 32'd0);

    // Two strobes before frame end: the later one wins
    for (int i = 0; i < 8; i++) begin
      i_pix_valid = 1'b1;
      if (i == 2)      set_ale(1'b1, 8'd1, 8'd1, 8'd1);
      else if (i == 3) set_ale(1'b1, 8'd2, 8'd2, 8'd2);
      else             set_ale(1'b0, 8'd0, 8'd0, 8'd0);
      tick;
    end
    i_pix_valid = 1'b0; set_ale(1'b0, 8'd0, 8'd0, 8'd0);
    chk("b2b_swap_a", 32'(a), 32'({8'd2, 8'd2, 8'd2}));

    // Stop mid-frame; 8 SRSC outputs spaced 3 cycles apart, 3 in RUN, 5 in DRAIN
    cnt_a = 0; cnt_b = 0; cyc_a = -1; cyc_b = -1;
    for (int c = 0; c < 25; c++) begin
      i_pix_valid  = (c < 8);
      i_stop       = (c == 2);
      i_srsc_valid = ((c % 3) == 0) && (c <= 21);
      tick;
      if (o_frame_done) begin cnt_a++; cyc_a = c; end
      if (o_done)       begin cnt_b++; cyc_b = c; end
      if (c == 7)  chk("drain_status", 32'(st), 32'(3'b101));
      if (c == 15) chk("drain_holds", 32'(st), 32'(3'b101));
    end
    i_pix_valid = 1'b0; i_stop = 1'b0; i_srsc_valid = 1'b0;
    chk("frame_done_once", 32'(cnt_a), 32'd1);
    chk("done_once", 32'(cnt_b), 32'd1);
    chk("frame_done_cycle", 32'(cyc_a), 32'd21);
    chk("done_cycle", 32'(cyc_b), 32'd21);
    chk("drain_to_idle", 32'(st), 32'(3'b000));

    // Second run: no A during priming -> WAIT_A
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("prime2_status", 32'(st), 32'(3'b110));
    for (int i = 0; i < 8; i++) begin
      i_pix_valid = 1'b1;
      tick;
    end
    chk("wait_a_status", 32'(st), 32'(3'b100));
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (o_pix_ready) cnt_a++;
    end
    chk("wait_a_ready_low", 32'(cnt_a), 32'd0);
    set_ale(1'b1, 8'd40, 8'd50, 8'd60);
    tick;
    set_ale(1'b0, 8'd0, 8'd0, 8'd0); i_pix_valid = 1'b0;
    chk("wait_a_swap", 32'(a), 32'({8'd40, 8'd50, 8'd60}));
    chk("wait_a_to_run", 32'(st), 32'(3'b111));

    // Start while running is ignored
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("start_ignored", 32'(st), 32'(3'b111));

    // Reset in the middle of a RUN frame, at pixel 3
    for (int i = 0; i < 3; i++) begin
      i_pix_valid = 1'b1;
      tick;
      if (i == 0) chk("wait_run_frame_start", 32'(o_frame_start), 32'd1);
    end
    rst = 1'b1; i_srsc_valid = 1'b1;
    set_ale(1'b1, 8'd9, 8'd9, 8'd9);
    tick;
    rst = 1'b0; i_pix_valid = 1'b0; i_srsc_valid = 1'b0;
    set_ale(1'b0, 8'd0, 8'd0, 8'd0);
    chk("midrst_status", 32'(st), 32'(3'b000));
    chk("midrst_a", 32'(a), 32'({8'd255, 8'd255, 8'd255}));
    chk("midrst_pulses", 32'(pulses), 32'(4'b0000));
    chk("midrst_shadow_v", 32'(dut.shadow_v), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/srsc_frame_sequencer.md
# srsc_frame_sequencer

Frame-level controller for the scene-recovery-with-saturation-correction datapath. It sequences each run of frames: a priming frame feeds atmospheric-light estimation only, then recovery frames stream through SRSC using the previous frame's atmospheric light A. It double-buffers the A estimate so that A is constant within a frame and swaps only on frame boundaries. It back-pressures the pixel source while A is unavailable, and counts SRSC outputs to report frame completion and drain.

## Interface
- IMG_W, 512, pixels per line
- IMG_H, 512, lines per frame
- A_DEFAULT, 8'd255, reset/initial value of the active A registers
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; honoured only in IDLE
- i_stop  in  1  stop request pulse; latched and acted on at the next input frame end
- i_pix_valid  in  1  source pixel valid; a pixel is accepted when i_pix_valid && o_pix_ready
- o_pix_ready  out  1  sequencer accepts pixels
- i_ale_r, i_ale_g, i_ale_b  in  8 each  A estimate from atmospheric-light estimation
- i_ale_valid  in  1  1-cycle strobe; the estimate is complete
- i_srsc_valid  in  1  SRSC o_valid; one per recovered pixel
- o_a_r, o_a_g, o_a_b  out  8 each  active A to SRSC i_a_*
- o_ale_in_valid  out  1  drives SRSC ale_in_valid
- o_frame_start  out  1  1-cycle pulse on acceptance of pixel (0,0)
- o_frame_done  out  1  1-cycle pulse when the IMG_W*IMG_H-th SRSC output of a frame is counted
- o_a_stale  out  1  1-cycle pulse when a recovery frame ends with no new A available
- o_done  out  1  1-cycle pulse on leaving DRAIN
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, PRIME, WAIT_A, RUN, DRAIN. Reset enters IDLE.
- Input counters col (0..IMG_W-1) and row (0..IMG_H-1) have $clog2 widths. They advance on each accepted pixel, and col wraps into row. Frame end (fe) is an accepted pixel with col=IMG_W-1 and row=IMG_H-1. Both counters wrap to 0 at fe.
- Shadow A (shadow_r/g/b, shadow_v): i_ale_valid loads the shadow and sets shadow_v in any state except IDLE. A second strobe before consumption overwrites the shadow.
- Swap: copy shadow to o_a_*, then clear shadow_v. If i_ale_valid coincides with the swap cycle, the incoming i_ale_* value is copied directly and shadow_v ends at 0.
- IDLE: on i_start, go to PRIME and clear the counters, shadow_v and the stop latch.
- PRIME: accept pixels; o_ale_in_valid=0. On fe:
  - if shadow_v or i_ale_valid, swap and go to RUN;
  - else go to WAIT_A.
- WAIT_A: o_pix_ready=0. On i_ale_valid, swap and go to RUN.
- RUN: accept pixels; o_ale_in_valid=1. On fe:
  - if shadow_v or i_ale_valid, swap; else keep o_a_* unchanged and pulse o_a_stale;
  - then, if the stop latch (or i_stop in the same cycle) is set, go to DRAIN; else stay in RUN.
- DRAIN: o_pix_ready=0; o_ale_in_valid=1. When the output counter wraps, pulse o_done and go to IDLE.
- Output counter: width $clog2(IMG_W*IMG_H). Counts i_srsc_valid in RUN and DRAIN. At IMG_W*IMG_H-1 plus one more valid, it wraps to 0 and pulses o_frame_done.
- If DRAIN is entered with the output counter already at 0 (all outputs already received), go to IDLE and pulse o_done on the next cycle.
- i_start outside IDLE is ignored. i_stop in PRIME or WAIT_A is latched and takes effect at the first RUN fe.
- rst mid-operation returns every register to its reset value in the next cycle. There is no partial-frame recovery.

## Timing
- Reset values:
  - state=IDLE;
  - o_a_r/g/b=A_DEFAULT;
  - o_pix_ready, o_ale_in_valid, o_frame_start, o_frame_done, o_a_stale, o_done, o_busy all 0;
  - counters 0; shadow_v=0.
- All outputs are registered or are decodes of registered state. There is no combinational path from any input to any output.
- o_pix_ready=1 exactly when state is PRIME or RUN. The cycle after an fe that leaves RUN or PRIME, o_pix_ready=0.
- A swap performed on an fe cycle is visible on o_a_* in the following cycle, before any pixel of the next frame can be accepted. A is therefore constant across every accepted pixel of a frame.
- Pulses (o_frame_start, o_frame_done, o_a_stale, o_done) assert in the cycle after the triggering event.
- The sequencer adds no latency to pixel data. It only gates acceptance.

## Test plan
- IMG_W=4, IMG_H=2; start, stream 8 pixels, i_ale_valid (A=90,80,70) at pixel 5 -> state RUN after fe; o_a=90,80,70 in the next cycle; o_ale_in_valid=1; o_pix_ready never drops.
- Same setup, no i_ale_valid during PRIME -> WAIT_A with o_pix_ready=0. i_ale_valid (A=40,50,60) 10 cycles later -> o_a=40,50,60, RUN, o_pix_ready=1.
- RUN frame with no new A -> o_a unchanged, o_a_stale pulses once. i_ale_valid on the exact fe cycle (A=11,22,33) -> o_a=11,22,33 next cycle, shadow_v=0.
- i_stop mid-frame, then 8 i_srsc_valid strobes spaced 3 cycles apart -> DRAIN after fe, o_pix_ready=0, o_frame_done and o_done each pulse once after the 8th strobe, then IDLE.
- rst asserted mid-RUN (pixel 3) -> next cycle: IDLE, o_a=255,255,255, all pulses 0. i_start during RUN is ignored (state unchanged).
- Back-to-back i_ale_valid (A=1,1,1 then 2,2,2) before fe -> swap yields 2,2,2.
